// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer.
// Consumed by fetch_ctrl (optional feature macro: FETCH_MISALIGN_CHECK_EN).
package fetch_pkg;

    localparam int XLEN_DEF = 32;
    localparam int INC      = 4;

    // A response is dropped when it was marked stale or a redirect lands with it.
    localparam bit DROP_ON_DISCARD  = 1'b1;
    localparam bit DROP_ON_REDIRECT = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        VALID,
        FAULT
    } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: next-PC, imem handshake, decode hand-off.
// Define FETCH_MISALIGN_CHECK_EN to trap misaligned redirect targets.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_cur,
    output logic [XLEN-1:0] pc_next,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            fault_valid,
    output logic [XLEN-1:0] fault_addr
);

    fetch_state_t    r_state;
    logic [XLEN-1:0] r_req_addr;
    logic [XLEN-1:0] r_instr_q;
    logic [XLEN-1:0] r_instr_pc_q;
    logic            r_discard;

    logic            w_misalign;
    logic            w_redir;
    logic            w_drop;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_pc_inc;

    assign w_pc_inc = pc_cur + XLEN'(INC);

`ifdef FETCH_MISALIGN_CHECK_EN
    logic            r_fault_valid;
    logic [XLEN-1:0] r_fault_addr;

    assign w_misalign = redirect_valid && (r_state != FAULT)
                        && (redirect_target[1:0] != 2'b00);
    assign w_target    = redirect_target;
    assign fault_valid = r_fault_valid;
    assign fault_addr  = r_fault_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fault_valid <= 1'b0;
            r_fault_addr  <= '0;
        end else if (w_misalign) begin
            r_fault_valid <= 1'b1;
            r_fault_addr  <= redirect_target;
        end
    end
`else
    // Low address bits are simply ignored when no trap is configured.
    assign w_misalign  = 1'b0;
    assign w_target    = redirect_target & ~(XLEN'(3));
    assign fault_valid = 1'b0;
    assign fault_addr  = '0;
`endif

    assign w_redir = redirect_valid && (r_state != FAULT) && !w_misalign;
    assign w_drop  = (DROP_ON_DISCARD && r_discard)
                     || (DROP_ON_REDIRECT && w_redir);

    always_comb begin
        pc_next = pc_cur;
        if (w_redir) begin
            pc_next = w_target;
        end else if (r_state == VALID && instr_ready) begin
            pc_next = w_pc_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_req_addr   <= '0;
            r_instr_q    <= '0;
            r_instr_pc_q <= '0;
            r_discard    <= 1'b0;
        end else if (w_misalign) begin
            r_state   <= FAULT;
            r_discard <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state    <= REQ;
                    r_req_addr <= pc_next;
                end
                REQ: begin
                    if (w_redir) r_discard <= 1'b1;
                    if (imem_gnt) r_state <= WAIT;
                end
                WAIT: begin
                    if (imem_rvalid && w_drop) begin
                        r_discard  <= 1'b0;
                        r_state    <= REQ;
                        r_req_addr <= pc_next;
                    end else if (imem_rvalid) begin
                        r_instr_q    <= imem_rdata;
                        r_instr_pc_q <= r_req_addr;
                        r_state      <= VALID;
                    end else if (w_redir) begin
                        r_discard <= 1'b1;
                    end
                end
                VALID: begin
                    if (w_redir || instr_ready) begin
                        r_state    <= REQ;
                        r_req_addr <= pc_next;
                    end
                end
                FAULT:   r_state <= FAULT;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign imem_req    = (r_state == REQ);
    assign instr_valid = (r_state == VALID);
    assign imem_addr   = r_req_addr;
    assign instr       = r_instr_q;
    assign instr_pc    = r_instr_pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl with a behavioural imem and PC register.
// Honours FETCH_MISALIGN_CHECK_EN for the misaligned-redirect expectations.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_cur, pc_next, imem_addr, imem_rdata;
    logic [31:0] instr, instr_pc, redirect_target, fault_addr;
    logic        imem_req, imem_gnt, imem_rvalid, instr_valid;
    logic        instr_ready, redirect_valid, fault_valid;

    int total = 0;
    int bad = 0;

    bit          pend;
    logic [31:0] pend_addr;
    int          pend_cnt, gnt_wait, gnt_cfg, rv_lat;
    bit          mem_rand;

    fetch_ctrl dut (
        .clk(clk), .reset(reset), .pc_cur(pc_cur), .pc_next(pc_next),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .fault_valid(fault_valid),
        .fault_addr(fault_addr)
    );

    always #5 clk = ~clk;

    // Core PC register
    always @(posedge clk) pc_cur <= reset ? 32'h0 : pc_next;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    // One clock; then the memory model reacts to what the DUT now shows.
    task automatic cycle();
        logic g, r;
        logic [31:0] a;
        g = imem_gnt;
        r = imem_rvalid;
        a = imem_addr;
        @(posedge clk);
        #1;
        if (r) pend = 1'b0;
        if (g) begin
            pend      = 1'b1;
            pend_addr = a;
            pend_cnt  = mem_rand ? int'($urandom_range(1, 3)) : rv_lat;
            gnt_wait  = mem_rand ? int'($urandom_range(0, 3)) : gnt_cfg;
        end
        imem_gnt = 1'b0;
        if (imem_req && !pend) begin
            if (gnt_wait == 0) imem_gnt = 1'b1;
            else gnt_wait--;
        end
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (pend) begin
            if (pend_cnt <= 1) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(pend_addr);
            end else begin
                pend_cnt--;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        redirect_valid = 1'b0;
        redirect_target = '0;
        instr_ready = 1'b0;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        pend = 1'b0;
        gnt_wait = gnt_cfg;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        mem_rand = 0; gnt_cfg = 0; rv_lat = 1;
        do_reset();
        total++;
        if ({imem_req, instr_valid, fault_valid} !== 3'b000) begin
            bad++;
            $display("FAIL reset_flags: got %b want 000",
                     {imem_req, instr_valid, fault_valid});
        end
        total++;
        if ({imem_addr, instr, instr_pc, fault_addr} !== 128'h0) begin
            bad++;
            $display("FAIL reset_data: got %h %h %h %h want 0",
                     imem_addr, instr, instr_pc, fault_addr);
        end
        cycle();
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            bad++;
            $display("FAIL reset_first_req: got req=%b addr=%h want 1 0",
                     imem_req, imem_addr);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] gaddr[$];
        logic [31:0] dpc[$];
        logic [31:0] dwd[$];
        int dcyc[$];
        logic [31:0] got;
        mem_rand = 0; gnt_cfg = 0; rv_lat = 1;
        do_reset();
        instr_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (imem_req && imem_gnt) gaddr.push_back(imem_addr);
            if (instr_valid) begin
                dpc.push_back(instr_pc);
                dwd.push_back(instr);
                dcyc.push_back(i);
            end
        end
        for (int k = 0; k < 3; k++) begin
            got = (k < gaddr.size()) ? gaddr[k] : 32'hxxxxxxxx;
            total++;
            if (got !== 32'(4 * k)) begin
                bad++;
                $display("FAIL seq_addr%0d: got %h want %h", k, got, 4 * k);
            end
            got = (k < dpc.size()) ? dpc[k] : 32'hxxxxxxxx;
            total++;
            if (got !== 32'(4 * k)) begin
                bad++;
                $display("FAIL seq_pc%0d: got %h want %h", k, got, 4 * k);
            end
            got = (k < dwd.size()) ? dwd[k] : 32'hxxxxxxxx;
            total++;
            if (got !== mem_word(32'(4 * k))) begin
                bad++;
                $display("FAIL seq_word%0d: got %h want %h",
                         k, got, mem_word(32'(4 * k)));
            end
        end
        total++;
        if (dcyc.size() < 3 || dcyc[1] - dcyc[0] != 3 || dcyc[2] - dcyc[1] != 3) begin
            bad++;
            $display("FAIL seq_rate: got %0d deliveries want 3-cycle spacing",
                     dcyc.size());
        end
    endtask

    task automatic test_backpressure();
        int stuck;
        mem_rand = 0; gnt_cfg = 0; rv_lat = 1;
        do_reset();
        instr_ready = 1'b1;
        for (int i = 0; i < 20 && !(instr_valid && instr_pc == 32'h4); i++) cycle();
        instr_ready = 1'b0;
        total++;
        if (!(instr_valid && instr_pc == 32'h4)) begin
            bad++;
            $display("FAIL bp_reach: got valid=%b pc=%h want 1 4", instr_valid, instr_pc);
        end
        stuck = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (instr_valid !== 1'b1 || instr !== mem_word(32'h4) || instr_pc !== 32'h4
                || pc_cur !== 32'h4 || imem_req !== 1'b0 || pc_next !== 32'h4)
                stuck++;
        end
        total++;
        if (stuck != 0) begin
            bad++;
            $display("FAIL bp_hold: got %0d bad cycles want 0 (pc=%h req=%b)",
                     stuck, pc_cur, imem_req);
        end
        instr_ready = 1'b1;
        cycle();
        total++;
        if (pc_cur !== 32'h8 || imem_req !== 1'b1 || imem_addr !== 32'h8) begin
            bad++;
            $display("FAIL bp_release: got pc=%h req=%b addr=%h want 8 1 8",
                     pc_cur, imem_req, imem_addr);
        end
    endtask

    task automatic test_redirect_valid();
        logic [31:0] gaddr[$];
        logic [31:0] fpc, fwd;
        bit seen;
        mem_rand = 0; gnt_cfg = 0; rv_lat = 1;
        do_reset();
        for (int i = 0; i < 20 && !instr_valid; i++) cycle();
        redirect_valid = 1'b1;
        redirect_target = 32'h100;
        instr_ready = 1'b1;
        #1;
        total++;
        if (pc_next !== 32'h100) begin
            bad++;
            $display("FAIL rv_pcnext: got %h want 00000100", pc_next);
        end
        cycle();
        redirect_valid = 1'b0;
        total++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            bad++;
            $display("FAIL rv_drop: got valid=%b req=%b addr=%h want 0 1 100",
                     instr_valid, imem_req, imem_addr);
        end
        seen = 0; fpc = 'x; fwd = 'x;
        for (int i = 0; i < 12; i++) begin
            if (imem_req && imem_gnt) gaddr.push_back(imem_addr);
            if (instr_valid && !seen) begin
                seen = 1; fpc = instr_pc; fwd = instr;
            end
            cycle();
        end
        total++;
        if (gaddr.size() < 2 || gaddr[0] !== 32'h100 || gaddr[1] !== 32'h104) begin
            bad++;
            $display("FAIL rv_addrs: got %0d grants want 100 then 104", gaddr.size());
        end
        total++;
        if (fpc !== 32'h100 || fwd !== mem_word(32'h100)) begin
            bad++;
            $display("FAIL rv_deliver: got %h/%h want 100/%h", fpc, fwd, mem_word(32'h100));
        end
    endtask

    task automatic test_redirect_req();
        logic [31:0] gaddr[$];
        logic [31:0] fpc, fwd;
        int held_bad;
        mem_rand = 0; gnt_cfg = 3; rv_lat = 1;
        do_reset();
        instr_ready = 1'b1;
        cycle();
        redirect_valid = 1'b1;
        redirect_target = 32'h40;
        #1;
        total++;
        if (imem_req !== 1'b1 || pc_next !== 32'h40) begin
            bad++;
            $display("FAIL rq_first: got req=%b pc_next=%h want 1 40", imem_req, pc_next);
        end
        cycle();
        redirect_valid = 1'b0;
        held_bad = 0; fpc = 'x; fwd = 'x;
        for (int i = 0; i < 40 && !instr_valid; i++) begin
            if (gaddr.size() == 0 && !(imem_req && imem_addr == 32'h0)) held_bad++;
            if (imem_req && imem_gnt) gaddr.push_back(imem_addr);
            cycle();
        end
        if (instr_valid) begin
            fpc = instr_pc; fwd = instr;
        end
        total++;
        if (held_bad != 0) begin
            bad++;
            $display("FAIL rq_hold: got %0d bad cycles want 0", held_bad);
        end
        total++;
        if (gaddr.size() != 2 || gaddr[0] !== 32'h0 || gaddr[1] !== 32'h40) begin
            bad++;
            $display("FAIL rq_addrs: got %0d grants want 0 then 40", gaddr.size());
        end
        total++;
        if (fpc !== 32'h40 || fwd !== mem_word(32'h40) || pc_cur !== 32'h40) begin
            bad++;
            $display("FAIL rq_deliver: got %h/%h pc=%h want 40/%h", fpc, fwd,
                     pc_cur, mem_word(32'h40));
        end
    endtask

    task automatic test_reset_wait();
        logic [31:0] gaddr[$];
        int early;
        mem_rand = 0; gnt_cfg = 0; rv_lat = 4;
        do_reset();
        instr_ready = 1'b1;
        for (int i = 0; i < 40 && !(pend && pend_addr == 32'h4); i++) cycle();
        total++;
        if (!(pend && pend_addr == 32'h4)) begin
            bad++;
            $display("FAIL rw_reach: got pend=%b addr=%h want 1 4", pend, pend_addr);
        end
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        early = 0;
        for (int i = 0; i < 40; i++) begin
            if (instr_valid) break;
            if (imem_req && imem_gnt) gaddr.push_back(imem_addr);
            if (gaddr.size() == 0 && pc_cur !== 32'h0) early++;
            cycle();
        end
        total++;
        if (early != 0 || gaddr.size() != 1 || gaddr[0] !== 32'h0) begin
            bad++;
            $display("FAIL rw_restart: got %0d grants, %0d pc errs want one grant at 0",
                     gaddr.size(), early);
        end
        total++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== mem_word(32'h0)) begin
            bad++;
            $display("FAIL rw_deliver: got v=%b %h/%h want 1 0/%h", instr_valid,
                     instr_pc, instr, mem_word(32'h0));
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc, want, tgt, prev_addr;
        bit prev_req, prev_gnt;
        int ndel;
        mem_rand = 1;
        do_reset();
        exp_pc = 32'h0; ndel = 0; prev_req = 0; prev_gnt = 0; prev_addr = '0;
        for (int i = 0; i < 800; i++) begin
            cycle();
            total++;
            if (pc_cur !== exp_pc) begin
                bad++;
                $display("FAIL rnd_pc@%0d: got %h want %h", i, pc_cur, exp_pc);
            end
            if (instr_valid) begin
                ndel++;
                total++;
                if (instr_pc !== exp_pc || instr !== mem_word(exp_pc)) begin
                    bad++;
                    $display("FAIL rnd_instr@%0d: got %h/%h want %h/%h", i,
                             instr_pc, instr, exp_pc, mem_word(exp_pc));
                end
            end
            total++;
            if ((imem_req && pend)
                || (prev_req && !prev_gnt && !(imem_req && imem_addr == prev_addr))) begin
                bad++;
                $display("FAIL rnd_proto@%0d: got req=%b addr=%h want held %h, none pending",
                         i, imem_req, imem_addr, prev_addr);
            end
            prev_req = imem_req; prev_gnt = imem_gnt; prev_addr = imem_addr;
            instr_ready = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 99) < 8);
            tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC
                                              : 32'($urandom_range(0, 1023)) << 2;
            redirect_target = tgt;
            #1;
            if (redirect_valid) want = tgt;
            else if (instr_valid && instr_ready) want = exp_pc + 32'd4;
            else want = exp_pc;
            total++;
            if (pc_next !== want) begin
                bad++;
                $display("FAIL rnd_pcnext@%0d: got %h want %h", i, pc_next, want);
            end
            exp_pc = want;
        end
        redirect_valid = 1'b0;
        total++;
        if (ndel < 20) begin
            bad++;
            $display("FAIL rnd_progress: got %0d deliveries want >=20", ndel);
        end
    endtask

    task automatic test_misalign();
        int active;
        mem_rand = 0; gnt_cfg = 0; rv_lat = 1;
        do_reset();
        for (int i = 0; i < 20 && !instr_valid; i++) cycle();
        redirect_valid = 1'b1;
        redirect_target = 32'h102;
        #1;
`ifdef FETCH_MISALIGN_CHECK_EN
        total++;
        if (pc_next !== 32'h0) begin
            bad++;
            $display("FAIL mis_pcnext: got %h want 00000000", pc_next);
        end
        cycle();
        redirect_valid = 1'b0;
        instr_ready = 1'b1;
        total++;
        if (fault_valid !== 1'b1 || fault_addr !== 32'h102) begin
            bad++;
            $display("FAIL mis_fault: got %b/%h want 1/102", fault_valid, fault_addr);
        end
        active = 0;
        for (int i = 0; i < 10; i++) begin
            redirect_valid = (i == 3);
            redirect_target = 32'h200;
            #1;
            if (imem_req || instr_valid || pc_next !== pc_cur) active++;
            cycle();
        end
        redirect_valid = 1'b0;
        total++;
        if (active != 0 || fault_valid !== 1'b1 || pc_cur !== 32'h0) begin
            bad++;
            $display("FAIL mis_stop: got %0d active cycles pc=%h want 0 0", active, pc_cur);
        end
`else
        total++;
        if (pc_next !== 32'h100) begin
            bad++;
            $display("FAIL mis_pcnext: got %h want 00000100", pc_next);
        end
        cycle();
        redirect_valid = 1'b0;
        instr_ready = 1'b1;
        total++;
        if (fault_valid !== 1'b0 || fault_addr !== 32'h0
            || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            bad++;
            $display("FAIL mis_noflt: got f=%b/%h req=%b addr=%h want 0/0 1 100",
                     fault_valid, fault_addr, imem_req, imem_addr);
        end
        active = 0;
        for (int i = 0; i < 20 && !instr_valid; i++) cycle();
        total++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h100) begin
            bad++;
            $display("FAIL mis_deliver: got v=%b pc=%h want 1 100", instr_valid, instr_pc);
        end
`endif
    endtask

    initial begin
        reset = 1'b1;
        instr_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = '0;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = '0;
        pend = 1'b0;
        pend_addr = '0;
        pend_cnt = 0;
        gnt_cfg = 0;
        gnt_wait = 0;
        rv_lat = 1;
        mem_rand = 0;
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_valid();
        test_redirect_req();
        test_reset_wait();
        test_random();
        test_misalign();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
